step_motor_seq: RTL and testbench
=================================

Name: step_motor_seq

Overview:
- Parametrised 4-coil stepper sequencer; successor to the combinational phase decoder.
- Generates the coil phase sequence internally from a start/step-count/period command, in full-step or half-step mode, either direction.
- Sits between the control MCU interface and the coil driver pins.
- Keeps the phase position between moves, so consecutive moves continue smoothly.

Parameters:
DIV_W, 16, width of the step-period divider (clock cycles per step)
CNT_W, 16, width of the step-count and remaining-step counters

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
enable  input  1  master enable; low de-energises the coils and aborts any move
start  input  1  single-cycle move request; accepted only in IDLE with enable=1
stop  input  1  synchronous abort of a running move
dir  input  1  1 = forward (phase index increments), 0 = reverse
half_mode  input  1  1 = half-step (8-state table), 0 = full-step
period  input  DIV_W  clock cycles per step; 0 is treated as 1
step_num  input  CNT_W  number of steps to move
coils  output  4  coil drive {A,B,a,b}
busy  output  1  high in RUN or DONE
done  output  1  one-cycle pulse when a move completes normally
step_pulse  output  1  one-cycle pulse on every phase advance
steps_left  output  CNT_W  remaining steps

Behaviour:
- Reset values (async, rst_n=0):
  - state=IDLE, phase index idx=0, divider=0.
  - coils=0, busy=0, done=0, step_pulse=0, steps_left=0.
- All outputs are registered.
- Phase table, indexed by idx[2:0]: 0:1000 1:1010 2:0010 3:0110 4:0100 5:0101 6:0001 7:1001.
- Step size:
  - Half-step: idx ±1 mod 8.
  - Full-step: idx ±2 mod 8. Parity is preserved; even idx gives wave drive, odd idx gives two-coil drive.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On start with enable=1, latch dir, half_mode, max(period,1) and step_num; steps_left<=step_num.
  - If step_num=0, go to DONE; otherwise go to RUN with divider=0.
  - start is ignored when busy=1.
- RUN:
  - divider increments every cycle.
  - When divider = period_eff-1:
    - Advance idx per latched dir/mode and reset divider to 0.
    - Decrement steps_left and assert step_pulse in the same cycle coils changes.
  - When the last step is taken (steps_left 1->0), go to DONE.
  - First coil change occurs period_eff cycles after the start cycle.
- DONE: done=1 for exactly one cycle, then return to IDLE.
- stop in RUN: go to IDLE next cycle, no done pulse; steps_left holds the remaining count; idx holds.
- stop and a step edge in the same cycle: the step is taken, then go to IDLE.
- enable=0 (any state): coils=0 next cycle, go to IDLE, no done pulse; idx is retained.
- Coils:
  - In RUN and DONE, coils = table[idx].
  - In IDLE, coils = 0 (see the optional feature below).
- idx is never cleared except by rst_n.
- Inputs other than start/stop/enable are don't-care outside the start cycle.

Optional Feature:
- Macro STEP_MOTOR_HOLD_EN.
- Defined: in IDLE with enable=1, coils = table[idx] (holding torque at the last position).
- Undefined: coils=0 whenever the FSM is in IDLE.
- enable=0 forces coils=0 in both builds.

Test Plan:
- Reset, then start with dir=1, half_mode=0, period=4, step_num=3:
  - coils = 0010, 0100, 0001 at cycles 4, 8, 12 after start.
  - Three step_pulse pulses; done at cycle 13; busy falls at cycle 14; steps_left 3->0.
- Half-step reverse from idx=0 (dir=0, half_mode=1, period=1, step_num=4):
  - coils = 1001, 0001, 0101, 0100 on consecutive cycles; done pulse follows.
- period=0, step_num=2: behaves exactly as period=1. step_num=0: done one cycle after start, coils unchanged, no step_pulse.
- Half-step 1 step (idx=1, coils 1010), then full-step forward 2 steps:
  - coils 0110 then 0101; parity is preserved.
- stop asserted mid-move at steps_left=5: no done, steps_left stays 5, busy=0. A start pulse during RUN is ignored (steps_left unaffected).
- enable dropped mid-move: coils=0 next cycle, no done. After enable returns and a new start, the sequence resumes from the retained idx. With STEP_MOTOR_HOLD_EN: IDLE coils equal the last phase.

Source files
------------

// File: rtl/step_motor_seq.sv
// step_motor_seq: 4-coil stepper sequencer. It generates the full-step or half-step
// phase sequence from a start / step-count / period command, in either direction.
// The phase index is kept between moves so that consecutive moves continue smoothly.
// Optional build macro STEP_MOTOR_HOLD_EN: when enabled, the last phase is held on
// the coils while the block is idle.
module step_motor_seq #(
  parameter int unsigned DIV_W = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             start,
  input  logic             stop,
  input  logic             dir,
  input  logic             half_mode,
  input  logic [DIV_W-1:0] period,
  input  logic [CNT_W-1:0] step_num,
  output logic [3:0]       coils,
  output logic             busy,
  output logic             done,
  output logic             step_pulse,
  output logic [CNT_W-1:0] steps_left
);

`ifdef STEP_MOTOR_HOLD_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [2:0]       idx, idx_nxt;
  logic [DIV_W-1:0] div_q, div_nxt;
  logic [DIV_W-1:0] per_q, per_nxt;
  logic [CNT_W-1:0] left_nxt;
  logic             dir_q, dir_nxt;
  logic             half_q, half_nxt;
  logic [2:0]       stride;
  logic [3:0]       coils_nxt;
  logic             busy_nxt, done_nxt, pulse_nxt;

  // Coil pattern {A,B,a,b} for each phase index
  function automatic logic [3:0] phase(input logic [2:0] i);
    case (i)
      3'd0: phase = 4'b1000;
      3'd1: phase = 4'b1010;
      3'd2: phase = 4'b0010;
      3'd3: phase = 4'b0110;
      3'd4: phase = 4'b0100;
      3'd5: phase = 4'b0101;
      3'd6: phase = 4'b0001;
      default: phase = 4'b1001;
    endcase
  endfunction

  // Next-state, phase advance and registered-output next values
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    div_nxt   = div_q;
    per_nxt   = per_q;
    left_nxt  = steps_left;
    dir_nxt   = dir_q;
    half_nxt  = half_q;
    pulse_nxt = 1'b0;
    stride    = half_q ? 3'd1 : 3'd2;

    if (!enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dir_nxt   = dir;
            half_nxt  = half_mode;
            per_nxt   = (period == '0) ? DIV_W'(1) : period;
            left_nxt  = step_num;
            div_nxt   = '0;
            state_nxt = (step_num == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (div_q == per_q - DIV_W'(1)) begin
            div_nxt   = '0;
            idx_nxt   = dir_q ? idx + stride : idx - stride;
            left_nxt  = steps_left - CNT_W'(1);
            pulse_nxt = 1'b1;
            if (steps_left == CNT_W'(1)) state_nxt = DONE;
          end else begin
            div_nxt = div_q + DIV_W'(1);
          end
          // A step landing on the same edge as stop is still taken
          if (stop) state_nxt = IDLE;
        end
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end

    if (enable && ((state_nxt != IDLE) || HOLD_EN)) coils_nxt = phase(idx_nxt);
    else                                            coils_nxt = 4'b0000;
    busy_nxt = (state_nxt != IDLE) || (state == DONE);
    done_nxt = (state == DONE) && enable;
  end

  // State, sequencing registers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= 3'd0;
      div_q      <= '0;
      per_q      <= DIV_W'(1);
      dir_q      <= 1'b1;
      half_q     <= 1'b0;
      coils      <= 4'b0000;
      busy       <= 1'b0;
      done       <= 1'b0;
      step_pulse <= 1'b0;
      steps_left <= '0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      div_q      <= div_nxt;
      per_q      <= per_nxt;
      dir_q      <= dir_nxt;
      half_q     <= half_nxt;
      coils      <= coils_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      step_pulse <= pulse_nxt;
      steps_left <= left_nxt;
    end
  end

endmodule

// File: tb/tb_step_motor_seq.sv
// Directed testbench for step_motor_seq. Expected values are computed by hand from
// the phase table and the timing of the move command.
module tb_step_motor_seq;

  localparam int unsigned DIV_W = 16;
  localparam int unsigned CNT_W = 16;
`ifdef STEP_MOTOR_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             enable, start, stop, dir, half_mode;
  logic [DIV_W-1:0] period;
  logic [CNT_W-1:0] step_num;
  logic [3:0]       coils;
  logic             busy, done, step_pulse;
  logic [CNT_W-1:0] steps_left;

  int checks = 0;
  int errors = 0;
  int pulses;
  int dones;

  step_motor_seq #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .start(start), .stop(stop),
    .dir(dir), .half_mode(half_mode), .period(period), .step_num(step_num),
    .coils(coils), .busy(busy), .done(done), .step_pulse(step_pulse),
    .steps_left(steps_left)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] ph(input int i);
    case (i & 7)
      0: ph = 4'b1000;
      1: ph = 4'b1010;
      2: ph = 4'b0010;
      3: ph = 4'b0110;
      4: ph = 4'b0100;
      5: ph = 4'b0101;
      6: ph = 4'b0001;
      default: ph = 4'b1001;
    endcase
  endfunction

  function automatic logic [3:0] idle_c(input int i);
    idle_c = HOLD ? ph(i) : 4'b0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a one-cycle start; returns just after the start edge
  task automatic move(input logic d, input logic h, input int p, input int n);
    dir = d; half_mode = h; period = DIV_W'(p); step_num = CNT_W'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; start = 1'b0; stop = 1'b0;
    dir = 1'b1; half_mode = 1'b0; period = '0; step_num = '0;
    #12;
    chk("rst_coils", 32'(coils), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pulse", 32'(step_pulse), 32'd0);
    chk("rst_left", 32'(steps_left), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();

    // Full-step forward, period 4, 3 steps: idx 0 -> 2 -> 4 -> 6
    move(1'b1, 1'b0, 4, 3);
    chk("t1_left0", 32'(steps_left), 32'd3);
    chk("t1_busy0", 32'(busy), 32'd1);
    pulses = 0; dones = 0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      pulses += int'(step_pulse);
      dones  += int'(done);
      if (k == 3)  chk("t1_c3", 32'(coils), 32'(ph(0)));
      if (k == 4)  chk("t1_c4", 32'(coils), 32'(ph(2)));
      if (k == 4)  chk("t1_p4", 32'(step_pulse), 32'd1);
      if (k == 8)  chk("t1_c8", 32'(coils), 32'(ph(4)));
      if (k == 12) chk("t1_c12", 32'(coils), 32'(ph(6)));
      if (k == 12) chk("t1_left12", 32'(steps_left), 32'd0);
      if (k == 13) chk("t1_done13", 32'(done), 32'd1);
      if (k == 13) chk("t1_busy13", 32'(busy), 32'd1);
      if (k == 14) chk("t1_busy14", 32'(busy), 32'd0);
    end
    chk("t1_pulses", 32'(pulses), 32'd3);
    chk("t1_dones", 32'(dones), 32'd1);

    // period=0 behaves as 1: half-step forward 2 steps, idx 6 -> 7 -> 0
    move(1'b1, 1'b1, 0, 2);
    tick(); chk("p0_c1", 32'(coils), 32'(ph(7))); chk("p0_p1", 32'(step_pulse), 32'd1);
    tick(); chk("p0_c2", 32'(coils), 32'(ph(0))); chk("p0_p2", 32'(step_pulse), 32'd1);
    tick(); chk("p0_done", 32'(done), 32'd1);

    // Half-step reverse from idx 0, period 1, 4 steps
    move(1'b0, 1'b1, 1, 4);
    tick(); chk("hr_c1", 32'(coils), 32'b1001);
    tick(); chk("hr_c2", 32'(coils), 32'b0001);
    tick(); chk("hr_c3", 32'(coils), 32'b0101);
    tick(); chk("hr_c4", 32'(coils), 32'b0100);
    tick(); chk("hr_done", 32'(done), 32'd1);

    // step_num=0 at idx 4: done one cycle after start, no step
    move(1'b1, 1'b0, 3, 0);
    chk("z_c0", 32'(coils), 32'(ph(4)));
    chk("z_p0", 32'(step_pulse), 32'd0);
    tick(); chk("z_done", 32'(done), 32'd1); chk("z_p1", 32'(step_pulse), 32'd0);
    tick(); chk("z_done2", 32'(done), 32'd0); chk("z_busy2", 32'(busy), 32'd0);

    // Full-step reverse 2 steps back to idx 0, then parity test
    move(1'b0, 1'b0, 1, 2);
    tick(); chk("fr_c1", 32'(coils), 32'(ph(2)));
    tick(); chk("fr_c2", 32'(coils), 32'(ph(0)));
    tick();
    move(1'b1, 1'b1, 1, 1);
    tick(); chk("par_h1", 32'(coils), 32'b1010);
    tick();
    move(1'b1, 1'b0, 1, 2);
    tick(); chk("par_f1", 32'(coils), 32'b0110);
    tick(); chk("par_f2", 32'(coils), 32'b0101);
    tick(); chk("par_done", 32'(done), 32'd1);

    // Stop mid-move at steps_left=5 (idx 5 -> 7 -> 1 -> 3); ignored start in RUN
    move(1'b1, 1'b0, 3, 8);
    dones = 0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      dones += int'(done);
      if (k == 4) begin step_num = CNT_W'(99); start = 1'b1; end
      if (k == 5) begin start = 1'b0; chk("st_ign", 32'(steps_left), 32'd7); end
    end
    chk("st_left9", 32'(steps_left), 32'd5);
    chk("st_c9", 32'(coils), 32'(ph(3)));
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("st_busy", 32'(busy), 32'd0);
    chk("st_left", 32'(steps_left), 32'd5);
    chk("st_coils", 32'(coils), 32'(idle_c(3)));
    for (int k = 0; k < 4; k++) begin
      tick();
      dones += int'(done);
    end
    chk("st_nodone", 32'(dones), 32'd0);
    chk("st_left_hold", 32'(steps_left), 32'd5);

    // Enable dropped mid-move (idx 3 -> 5 -> 7), then resume from idx 7
    move(1'b1, 1'b0, 2, 4);
    tick(); tick(); tick(); tick();
    chk("en_c4", 32'(coils), 32'(ph(7)));
    enable = 1'b0;
    tick();
    chk("en_coils", 32'(coils), 32'd0);
    chk("en_busy", 32'(busy), 32'd0);
    dones = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      dones += int'(done);
    end
    chk("en_nodone", 32'(dones), 32'd0);
    chk("en_coils_off", 32'(coils), 32'd0);
    enable = 1'b1;
    tick();
    chk("en_idle", 32'(coils), 32'(idle_c(7)));
    move(1'b1, 1'b1, 1, 1);
    tick(); chk("en_res_c", 32'(coils), 32'(ph(0))); chk("en_res_p", 32'(step_pulse), 32'd1);
    tick(); chk("en_res_done", 32'(done), 32'd1);
    tick(); chk("en_idle2", 32'(coils), 32'(idle_c(0)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
